// File: rtl/regfile_sb.sv
// Multi-port integer register file with two write ports, optional write-to-read
// bypass and a per-register pending-write scoreboard for decode stall logic.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRP*AW-1:0]     rd_addr,
    output logic [NRP*XLEN-1:0]   rd_data,
    output logic [NRP-1:0]        rd_busy,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [AW:0]           busy_cnt,
    output logic                  idle
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            wa_act, wb_act;

    assign wa_act = wa_en && (wa_addr != '0);
    assign wb_act = wb_en && (wb_addr != '0);

    // A new issue outranks a same-cycle writeback: the new producer owns the register.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (iss_en && (iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wa_en && (wa_addr == AW'(r))) || (wb_en && (wb_addr == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Port B is written last so it wins an address collision with port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (wa_act) regs_q[wa_addr] <= wa_data;
            if (wb_act) regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        a       = '0;
        d       = '0;
        b       = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRP; i++) begin
            a = rd_addr[i*AW +: AW];
            d = regs_q[a];
            b = busy_q[a];
            if (BYPASS != 0) begin
                if ((wb_act && (wb_addr == a)) || (wa_act && (wa_addr == a))) begin
                    d = (wb_act && (wb_addr == a)) ? wb_data : wa_data;
                    b = iss_en && (iss_addr == a);
                end
            end
            if (a == '0) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[i*XLEN +: XLEN] = d;
            rd_busy[i]              = b;
        end
    end

    assign busy_cnt = cnt_q;
    assign idle     = (cnt_q == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb; a BYPASS=0 twin shares all inputs so
// both read-path flavours are checked against hand-computed values.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_n;
    logic [1:0]  rd_busy, rd_busy_n;
    logic        wa_en, wb_en, iss_en;
    logic [4:0]  wa_addr, wb_addr, iss_addr;
    logic [31:0] wa_data, wb_data;
    logic [5:0]  busy_cnt, busy_cnt_n;
    logic        idle, idle_n;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt), .idle(idle)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_n), .idle(idle_n)
    );

    typedef struct {
        logic        rst;
        logic        wae; logic [4:0] waa; logic [31:0] wad;
        logic        wbe; logic [4:0] wba; logic [31:0] wbd;
        logic        ise; logic [4:0] isa;
        logic [4:0]  r0;  logic [4:0] r1;
        logic [31:0] d0;  logic [31:0] d1;
        logic        b0;  logic b1;
        logic [5:0]  cnt;
        logic [31:0] nd0; logic nb0;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                         input logic be, input logic [4:0] ba, input logic [31:0] bd,
                         input logic ie, input logic [4:0] ia, input logic [4:0] a0,
                         input logic [4:0] a1);
        rst = r; wa_en = ae; wa_addr = aa; wa_data = ad; wb_en = be; wb_addr = ba; wb_data = bd;
        iss_en = ie; iss_addr = ia; rd_addr = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst wae waa  wad           wbe wba  wbd    ise isa  r0  r1   d0            d1            b0 b1 cnt nd0           nb0
        tbl[0]  = '{0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0, 6'd0, 32'h0,        0};
        tbl[1]  = '{0, 1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0, 6'd0, 32'h0,        0};
        tbl[2]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0, 6'd0, 32'h0,        0};
        tbl[3]  = '{0, 1, 5'd7, 32'h11,       1, 5'd7, 32'h22, 0, 5'd0, 5'd7, 5'd7, 32'h22,       32'h22,       0, 0, 6'd0, 32'h0,        0};
        tbl[4]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 0, 0, 6'd0, 32'h22,       0};
        tbl[5]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd3, 5'd3, 5'd4, 32'h0,        32'h0,        0, 0, 6'd0, 32'h0,        0};
        tbl[6]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd4, 5'd3, 5'd4, 32'h0,        32'h0,        1, 0, 6'd1, 32'h0,        1};
        tbl[7]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd3, 5'd4, 32'h0,        32'h0,        1, 1, 6'd2, 32'h0,        1};
        tbl[8]  = '{0, 0, 5'd0, 32'h0,        1, 5'd3, 32'h55, 0, 5'd0, 5'd3, 5'd4, 32'h55,       32'h0,        0, 1, 6'd2, 32'h0,        1};
        tbl[9]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd3, 5'd4, 32'h55,       32'h0,        0, 1, 6'd1, 32'h55,       0};
        tbl[10] = '{0, 1, 5'd9, 32'hAA,       0, 5'd0, 32'h0,  1, 5'd9, 5'd9, 5'd9, 32'hAA,       32'hAA,       1, 1, 6'd1, 32'h0,        0};
        tbl[11] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd0, 5'd9, 5'd0, 32'hAA,       32'h0,        1, 0, 6'd2, 32'hAA,       1};
        tbl[12] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd2, 5'd2, 5'd0, 32'h0,        32'h0,        0, 0, 6'd2, 32'h0,        0};
        tbl[13] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd4, 5'd4, 5'd2, 32'h0,        32'h0,        1, 1, 6'd3, 32'h0,        1};
        tbl[14] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd4, 5'd9, 32'h0,        32'hAA,       1, 1, 6'd3, 32'h0,        1};
        tbl[15] = '{0, 1, 5'd2, 32'h77,       0, 5'd0, 32'h0,  0, 5'd0, 5'd2, 5'd9, 32'h77,       32'hAA,       0, 1, 6'd3, 32'h0,        1};
        tbl[16] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd10, 5'd2, 5'd10, 32'h77,     32'h0,        0, 0, 6'd2, 32'h77,       0};
        // Reset edge with a write and an issue in flight: both must be dropped.
        tbl[17] = '{1, 1, 5'd2, 32'hFF,       0, 5'd0, 32'h0,  1, 5'd11, 5'd9, 5'd10, 32'hAA,     32'h0,        1, 1, 6'd3, 32'hAA,       1};
        tbl[18] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd2, 5'd9, 32'h0,        32'h0,        0, 0, 6'd0, 32'h0,        0};
        tbl[19] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd11, 5'd5, 32'h0,       32'h0,        0, 0, 6'd0, 32'h0,        0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_cnt", 32'(busy_cnt), 32'd0);
        chk("reset_idle", 32'(idle), 32'd1);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk("reset_rd_data", rd_data[31:0] | rd_data[63:32] | rd_data_n[31:0] | rd_data_n[63:32],
                32'd0);
            chk("reset_rd_busy", 32'({rd_busy, rd_busy_n}), 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].wae, tbl[i].waa, tbl[i].wad, tbl[i].wbe, tbl[i].wba,
                  tbl[i].wbd, tbl[i].ise, tbl[i].isa, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("v%0d_d0", i), rd_data[31:0], tbl[i].d0);
            chk($sformatf("v%0d_d1", i), rd_data[63:32], tbl[i].d1);
            chk($sformatf("v%0d_b0", i), 32'(rd_busy[0]), 32'(tbl[i].b0));
            chk($sformatf("v%0d_b1", i), 32'(rd_busy[1]), 32'(tbl[i].b1));
            chk($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tbl[i].cnt == 6'd0));
            chk($sformatf("v%0d_nb_d0", i), rd_data_n[31:0], tbl[i].nd0);
            chk($sformatf("v%0d_nb_b0", i), 32'(rd_busy_n[0]), 32'(tbl[i].nb0));
            chk($sformatf("v%0d_nb_cnt", i), 32'(busy_cnt_n), 32'(tbl[i].cnt));
            tick();
        end

        // Two pending registers retired together through both write ports.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd6, 5'd8);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd6, 5'd8);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd8);
        #1;
        chk("seq_cnt2", 32'(busy_cnt), 32'd2);
        chk("seq_busy2", 32'(rd_busy_n), 32'd3);
        drive(0, 1, 5'd6, 32'h600D, 1, 5'd8, 32'hBEEF, 0, 0, 5'd6, 5'd8);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd8);
        #1;
        chk("seq_cnt0", 32'(busy_cnt), 32'd0);
        chk("seq_idle", 32'(idle), 32'd1);
        chk("seq_busy0", 32'({rd_busy, rd_busy_n}), 32'd0);
        chk("seq_d6", rd_data_n[31:0], 32'h600D);
        chk("seq_d8", rd_data_n[63:32], 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the decode stage.
- Generalises the single-write/two-read file to N read ports, two write ports (ALU + load writeback), an optional same-cycle write-to-read bypass, and a per-register scoreboard of pending writes that feeds decode stall logic.
- Sits between decode (reads, issue) and the writeback stage (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; register 0 reads as zero.
- AW, 5, address width; must equal clog2(NREG).
- NRP, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads see stored value only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NRP*AW  read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRP*XLEN  read data; port i is bits [i*XLEN +: XLEN].
- rd_busy  out  NRP  1 = register addressed by port i has a pending write not yet satisfied.
- wa_en  in  1  write port A enable (ALU writeback).
- wa_addr  in  AW  write port A address.
- wa_data  in  XLEN  write port A data.
- wb_en  in  1  write port B enable (load writeback).
- wb_addr  in  AW  write port B address.
- wb_data  in  XLEN  write port B data.
- iss_en  in  1  issue of an instruction that will write iss_addr; marks it pending.
- iss_addr  in  AW  destination of issued instruction.
- busy_cnt  out  AW+1  number of registers currently pending (registered).
- idle  out  1  1 when busy_cnt == 0.

Behaviour:
- Reset: the posedge with rst=1 clears all NREG registers to 0, all busy bits to 0 and busy_cnt to 0. Writes and issue are ignored on that edge. After the edge, every rd_data = 0, rd_busy = 0 and idle = 1.
- Storage: writes commit on posedge when rst=0. Address 0 is never written, never marked busy, and always reads 0 on every port regardless of bypass.
- Write collision: wa_en and wb_en to the same nonzero address in the same cycle store wb_data; port B wins.
- Reads are combinational from stored state; there is no read latency.
  - BYPASS=1: if a port's address matches an enabled nonzero write this cycle, rd_data is the write data (B over A). rd_busy for that port is 0 unless iss_en also targets the same address this cycle.
  - BYPASS=0: rd_data is the stored value and rd_busy is the stored busy bit. Written data is visible from the next cycle.
- Scoreboard, per nonzero register r, evaluated at posedge:
  - set if iss_en && iss_addr==r;
  - else cleared if (wa_en && wa_addr==r) || (wb_en && wb_addr==r);
  - else held.
  - Issue and writeback to the same register in one cycle: the bit stays/becomes set, because the new producer wins.
  - Writeback to a non-busy register still writes data; the bit stays 0.
  - Re-issue to an already busy register keeps it set and does not change the count.
- busy_cnt: registered popcount of busy bits, updated on the same edge as the bits. Its range is 0..NREG-1. idle is combinational from busy_cnt.
- rd_busy combinationally reflects the stored busy bit, with the bypass override described above.
- Reset asserted mid-operation, including with writes or issue active, takes priority over all updates. Pending state is lost.
- No X propagation: unenabled write addresses and data are don't-care and must not affect state.

Test Plan:
1. Reset, then read all addresses on both ports -> every rd_data = 0, rd_busy = 0, idle = 1, busy_cnt = 0.
2. Write wa x5=0xDEADBEEF, then read x5 next cycle -> 0xDEADBEEF. Write wa x0=0x1234 -> x0 still reads 0.
3. Same cycle: wa x7=0x11, wb x7=0x22 -> x7 = 0x22. With BYPASS=1, a same-cycle read of x7 returns 0x22; with BYPASS=0 it returns the old value, then 0x22 next cycle.
4. Issue x3, then x4 on consecutive cycles -> busy_cnt 1, then 2, and rd_busy set for x3/x4. Write wb x3=0x55 -> with BYPASS=1 a same-cycle read of x3 shows 0x55 and rd_busy 0; busy_cnt = 1 next cycle.
5. Same cycle: iss x9 and wa x9=0xAA -> x9 stores 0xAA, its busy bit is 1 after the edge, busy_cnt +1. Issue to x0 -> no count change.
6. With busy_cnt=3 and writes pending, assert rst for one cycle alongside wa x2=0xFF -> x2 = 0, busy_cnt = 0, idle = 1.
